regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the integer pipeline, with a configurable hardwired zero register and same-cycle write-to-read forwarding. Adds a reset-time clear sequencer that zeroes the array one entry per cycle, and a per-register busy scoreboard for pending writes. Sits between decode (read and reserve) and writeback (write and clear-busy).

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write/reserve requests and status.
// Decode/writeback side uses master; the register file uses slave.
interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NREAD*AW-1:0]   in_reg_number;
   logic [NREAD*XLEN-1:0] out_reg_value;
   logic [NREAD-1:0]      out_reg_busy;
   logic                  in_write_enable;
   logic [AW-1:0]         in_write_number;
   logic [XLEN-1:0]       in_write_value;
   logic                  in_reserve_enable;
   logic [AW-1:0]         in_reserve_number;
   logic                  in_write_flip_parity;
   logic [NREAD-1:0]      out_parity_err;
   logic                  out_ready;

   modport master (
      output in_reg_number, in_write_enable, in_write_number, in_write_value,
             in_reserve_enable, in_reserve_number, in_write_flip_parity,
      input  out_reg_value, out_reg_busy, out_parity_err, out_ready
   );

   modport slave (
      input  in_reg_number, in_write_enable, in_write_number, in_write_value,
             in_reserve_enable, in_reserve_number, in_write_flip_parity,
      output out_reg_value, out_reg_busy, out_parity_err, out_ready
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, write forwarding, clear sequencer
// and busy scoreboard. Optional per-entry even parity under REGFILE_PARITY_EN.
//
// state | meaning
// CLEAR | zeroing one entry per cycle; writes/reserves ignored, reads return 0
// READY | array usable; reads, writes and reserves active
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_mp_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic {CLEAR, READY} state_t;

   state_t           state;
   logic [AW-1:0]    clr_cnt;
   logic [NREGS-1:0] busy;
   logic [XLEN-1:0]  mem [NREGS];

   logic             wr_ok;
   logic             rs_ok;
   logic [AW-1:0]    rd_idx [NREAD];
   logic [NREAD*XLEN-1:0] rd_val;
   logic [NREAD-1:0] rd_busy;
   logic [NREAD-1:0] rd_err;

   assign wr_ok = bus.in_write_enable && !(ZERO_REG != 0 && bus.in_write_number == '0);
   assign rs_ok = bus.in_reserve_enable && !(ZERO_REG != 0 && bus.in_reserve_number == '0);

   for (genvar g = 0; g < NREAD; g++) begin : g_idx
      assign rd_idx[g] = bus.in_reg_number[g*AW +: AW];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         busy    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + AW'(1);
               if (clr_cnt == AW'(NREGS - 1)) state <= READY;
            end
            READY: begin
               // reserve is applied after the write so a same-index pair leaves busy set
               if (wr_ok) busy[bus.in_write_number] <= 1'b0;
               if (rs_ok) busy[bus.in_reserve_number] <= 1'b1;
            end
            default: state <= CLEAR;
         endcase
      end
   end

`ifdef REGFILE_PARITY_EN
   logic par [NREGS];
   logic wr_par;

   assign wr_par = (^bus.in_write_value) ^ bus.in_write_flip_parity;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
            par[clr_cnt] <= 1'b0;
         end else if (wr_ok) begin
            mem[bus.in_write_number] <= bus.in_write_value;
            par[bus.in_write_number] <= wr_par;
         end
      end
   end
`else
   logic unused_flip;
   assign unused_flip = bus.in_write_flip_parity;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) mem[clr_cnt] <= '0;
         else if (wr_ok) mem[bus.in_write_number] <= bus.in_write_value;
      end
   end
`endif

   always_comb begin
      rd_val  = '0;
      rd_busy = '0;
      rd_err  = '0;
      if (state == READY) begin
         for (int i = 0; i < NREAD; i++) begin
            if (ZERO_REG != 0 && rd_idx[i] == '0) begin
               rd_val[i*XLEN +: XLEN] = '0;
            end else if (bus.in_write_enable && rd_idx[i] == bus.in_write_number) begin
               rd_val[i*XLEN +: XLEN] = bus.in_write_value;
            end else begin
               rd_val[i*XLEN +: XLEN] = mem[rd_idx[i]];
               rd_busy[i]             = busy[rd_idx[i]];
`ifdef REGFILE_PARITY_EN
               rd_err[i]              = par[rd_idx[i]] ^ (^mem[rd_idx[i]]);
`endif
            end
         end
      end
   end

   assign bus.out_reg_value  = rd_val;
   assign bus.out_reg_busy   = rd_busy;
   assign bus.out_parity_err = rd_err;
   assign bus.out_ready      = (state == READY);
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, ZERO_REG=0 build and a 4-port 64-bit build.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus0 ();
   regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus1 ();
   regfile_mp_if #(.XLEN(64), .NREGS(16), .NREAD(4)) bus2 ();

   regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(4), .ZERO_REG(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus0.in_write_enable = 0; bus0.in_reserve_enable = 0; bus0.in_write_flip_parity = 0;
      bus1.in_write_enable = 0; bus1.in_reserve_enable = 0; bus1.in_write_flip_parity = 0;
      bus2.in_write_enable = 0; bus2.in_reserve_enable = 0; bus2.in_write_flip_parity = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      bus0.in_reg_number = {5'd9, 5'd5};
      repeat (3) step();
      n_checks++;
      if (bus0.out_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready_low: got %b expected 0", bus0.out_ready);
      end
      rst_n = 1;
      repeat (10) step();
      n_checks++;
      if (bus0.out_ready !== 1'b0 || bus0.out_reg_value !== 64'h0 || bus0.out_reg_busy !== 2'b00) begin
         n_fail++; $display("FAIL clear_outputs: ready %b value %h busy %b expected 0/0/0",
                            bus0.out_ready, bus0.out_reg_value, bus0.out_reg_busy);
      end
      // restart mid-clear; dut2 is also hit with a write that must be ignored
      rst_n = 0;
      step();
      rst_n = 1;
      bus2.in_write_enable = 1; bus2.in_write_number = 4'd5; bus2.in_write_value = 64'hAAAA_5555_1234_5678;
      for (int e = 1; e <= 32; e++) begin
         step();
         if (e == 12) bus2.in_write_enable = 0;
         if (e == 15) begin
            n_checks++;
            if (bus2.out_ready !== 1'b0) begin
               n_fail++; $display("FAIL dut2_ready_e15: got %b expected 0", bus2.out_ready);
            end
         end
         if (e == 16) begin
            n_checks++;
            if (bus2.out_ready !== 1'b1) begin
               n_fail++; $display("FAIL dut2_ready_e16: got %b expected 1", bus2.out_ready);
            end
         end
         if (e == 31) begin
            n_checks++;
            if (bus0.out_ready !== 1'b0 || bus1.out_ready !== 1'b0) begin
               n_fail++; $display("FAIL ready_e31: got %b %b expected 0 0", bus0.out_ready, bus1.out_ready);
            end
         end
         if (e == 32) begin
            n_checks++;
            if (bus0.out_ready !== 1'b1 || bus1.out_ready !== 1'b1) begin
               n_fail++; $display("FAIL ready_e32: got %b %b expected 1 1", bus0.out_ready, bus1.out_ready);
            end
         end
      end
      for (int r = 0; r < 32; r++) begin
         bus0.in_reg_number = {5'(31 - r), 5'(r)};
         bus1.in_reg_number = {5'(r), 5'(31 - r)};
         #1;
         n_checks++;
         if (bus0.out_reg_value !== 64'h0 || bus1.out_reg_value !== 64'h0 ||
             bus0.out_reg_busy !== 2'b00 || bus1.out_reg_busy !== 2'b00) begin
            n_fail++; $display("FAIL cleared_read r%0d: got %h %h busy %b %b expected zeros", r,
                               bus0.out_reg_value, bus1.out_reg_value, bus0.out_reg_busy, bus1.out_reg_busy);
         end
      end
      bus2.in_reg_number = {4'd5, 4'd5, 4'd5, 4'd5};
      #1;
      n_checks++;
      if (bus2.out_reg_value !== 256'h0) begin
         n_fail++; $display("FAIL clear_write_ignored: got %h expected 0", bus2.out_reg_value[63:0]);
      end
   endtask

   task automatic test_forward();
      bus0.in_write_enable = 1; bus0.in_write_number = 5'd5; bus0.in_write_value = 32'hDEAD_BEEF;
      bus0.in_reg_number = {5'd5, 5'd5};
      #1;
      n_checks++;
      if (bus0.out_reg_value !== {32'hDEAD_BEEF, 32'hDEAD_BEEF} || bus0.out_reg_busy !== 2'b00) begin
         n_fail++; $display("FAIL forward_same_cycle: got %h busy %b expected deadbeef x2 busy 00",
                            bus0.out_reg_value, bus0.out_reg_busy);
      end
      step();
      bus0.in_write_enable = 0;
      #1;
      n_checks++;
      if (bus0.out_reg_value[31:0] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL forward_array: got %h expected deadbeef", bus0.out_reg_value[31:0]);
      end
   endtask

   task automatic test_zero_reg();
      bus0.in_write_enable = 1; bus0.in_write_number = 5'd0; bus0.in_write_value = 32'h1234;
      bus0.in_reserve_enable = 1; bus0.in_reserve_number = 5'd0;
      bus0.in_reg_number = {5'd0, 5'd0};
      bus1.in_write_enable = 1; bus1.in_write_number = 5'd0; bus1.in_write_value = 32'h1234;
      bus1.in_reserve_enable = 1; bus1.in_reserve_number = 5'd0;
      bus1.in_reg_number = {5'd0, 5'd0};
      #1;
      n_checks++;
      if (bus0.out_reg_value !== 64'h0 || bus0.out_reg_busy !== 2'b00) begin
         n_fail++; $display("FAIL zero_no_forward: got %h busy %b expected 0 busy 00",
                            bus0.out_reg_value, bus0.out_reg_busy);
      end
      n_checks++;
      if (bus1.out_reg_value !== {32'h1234, 32'h1234}) begin
         n_fail++; $display("FAIL nozero_forward: got %h expected 1234 x2", bus1.out_reg_value);
      end
      step();
      idle_all();
      #1;
      n_checks++;
      if (bus0.out_reg_value !== 64'h0 || bus0.out_reg_busy !== 2'b00) begin
         n_fail++; $display("FAIL zero_after: got %h busy %b expected 0 busy 00",
                            bus0.out_reg_value, bus0.out_reg_busy);
      end
      n_checks++;
      if (bus1.out_reg_value !== {32'h1234, 32'h1234} || bus1.out_reg_busy !== 2'b11) begin
         n_fail++; $display("FAIL nozero_after: got %h busy %b expected 1234 x2 busy 11",
                            bus1.out_reg_value, bus1.out_reg_busy);
      end
   endtask

   task automatic test_scoreboard();
      bus0.in_reserve_enable = 1; bus0.in_reserve_number = 5'd7;
      bus0.in_reg_number = {5'd6, 5'd7};
      step();
      bus0.in_reserve_enable = 0;
      #1;
      n_checks++;
      if (bus0.out_reg_busy !== 2'b01 || bus0.out_reg_value[31:0] !== 32'h0) begin
         n_fail++; $display("FAIL reserve_busy: got busy %b value %h expected 01 0",
                            bus0.out_reg_busy, bus0.out_reg_value[31:0]);
      end
      bus0.in_write_enable = 1; bus0.in_write_number = 5'd7; bus0.in_write_value = 32'h55;
      #1;
      n_checks++;
      if (bus0.out_reg_busy !== 2'b00 || bus0.out_reg_value[31:0] !== 32'h55) begin
         n_fail++; $display("FAIL write_clears_fwd: got busy %b value %h expected 00 55",
                            bus0.out_reg_busy, bus0.out_reg_value[31:0]);
      end
      step();
      bus0.in_write_enable = 0;
      #1;
      n_checks++;
      if (bus0.out_reg_busy !== 2'b00 || bus0.out_reg_value[31:0] !== 32'h55) begin
         n_fail++; $display("FAIL write_clears_after: got busy %b value %h expected 00 55",
                            bus0.out_reg_busy, bus0.out_reg_value[31:0]);
      end
      bus0.in_write_enable = 1; bus0.in_write_number = 5'd7; bus0.in_write_value = 32'h55;
      bus0.in_reserve_enable = 1; bus0.in_reserve_number = 5'd7;
      bus0.in_reg_number = {5'd7, 5'd7};
      step();
      idle_all();
      #1;
      n_checks++;
      if (bus0.out_reg_busy !== 2'b11 || bus0.out_reg_value !== {32'h55, 32'h55}) begin
         n_fail++; $display("FAIL reserve_wins: got busy %b value %h expected 11 55 x2",
                            bus0.out_reg_busy, bus0.out_reg_value);
      end
   endtask

   task automatic test_multiport();
      logic [63:0] vals [4];
      vals[0] = 64'h1111_0000_0000_0001;
      vals[1] = 64'h2222_0000_0000_0002;
      vals[2] = 64'h3333_0000_0000_0003;
      vals[3] = 64'h4444_0000_0000_0004;
      for (int r = 0; r < 4; r++) begin
         bus2.in_write_enable = 1; bus2.in_write_number = 4'(r + 1); bus2.in_write_value = vals[r];
         step();
      end
      bus2.in_write_enable = 0;
      bus2.in_reg_number = {4'd4, 4'd3, 4'd2, 4'd1};
      #1;
      n_checks++;
      if (bus2.out_reg_value !== {vals[3], vals[2], vals[1], vals[0]} || bus2.out_reg_busy !== 4'b0000) begin
         n_fail++; $display("FAIL multiport_distinct: got %h busy %b", bus2.out_reg_value, bus2.out_reg_busy);
      end
      bus2.in_reg_number = {4'd3, 4'd3, 4'd3, 4'd3};
      #1;
      n_checks++;
      if (bus2.out_reg_value !== {vals[2], vals[2], vals[2], vals[2]}) begin
         n_fail++; $display("FAIL multiport_same: got %h expected %h x4", bus2.out_reg_value, vals[2]);
      end
   endtask

   task automatic test_parity();
      logic exp_err;
`ifdef REGFILE_PARITY_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      bus0.in_write_enable = 1; bus0.in_write_number = 5'd3; bus0.in_write_value = 32'h1;
      bus0.in_write_flip_parity = 1;
      bus0.in_reg_number = {5'd2, 5'd3};
      #1;
      n_checks++;
      if (bus0.out_parity_err !== 2'b00) begin
         n_fail++; $display("FAIL parity_forward: got %b expected 00", bus0.out_parity_err);
      end
      step();
      idle_all();
      #1;
      n_checks++;
      if (bus0.out_parity_err !== {1'b0, exp_err} || bus0.out_reg_value[31:0] !== 32'h1) begin
         n_fail++; $display("FAIL parity_flipped: got err %b value %h expected err %b value 1",
                            bus0.out_parity_err, bus0.out_reg_value[31:0], {1'b0, exp_err});
      end
      bus0.in_write_enable = 1; bus0.in_write_number = 5'd3; bus0.in_write_value = 32'h1;
      step();
      idle_all();
      #1;
      n_checks++;
      if (bus0.out_parity_err !== 2'b00) begin
         n_fail++; $display("FAIL parity_rewrite: got %b expected 00", bus0.out_parity_err);
      end
   endtask

   task automatic test_reset_in_ready();
      bus0.in_reserve_enable = 1; bus0.in_reserve_number = 5'd9;
      bus0.in_reg_number = {5'd5, 5'd9};
      step();
      bus0.in_reserve_enable = 0;
      #1;
      n_checks++;
      if (bus0.out_reg_busy !== 2'b01) begin
         n_fail++; $display("FAIL pre_reset_busy: got %b expected 01", bus0.out_reg_busy);
      end
      rst_n = 0;
      step();
      n_checks++;
      if (bus0.out_ready !== 1'b0 || bus0.out_reg_value !== 64'h0) begin
         n_fail++; $display("FAIL reenter_clear: ready %b value %h expected 0 0",
                            bus0.out_ready, bus0.out_reg_value);
      end
      rst_n = 1;
      repeat (32) step();
      n_checks++;
      if (bus0.out_ready !== 1'b1 || bus0.out_reg_busy !== 2'b00 || bus0.out_reg_value !== 64'h0) begin
         n_fail++; $display("FAIL after_reclear: ready %b busy %b value %h expected 1 00 0",
                            bus0.out_ready, bus0.out_reg_busy, bus0.out_reg_value);
      end
   endtask

   initial begin
      bus0.in_reg_number = '0; bus0.in_write_number = '0; bus0.in_write_value = '0; bus0.in_reserve_number = '0;
      bus1.in_reg_number = '0; bus1.in_write_number = '0; bus1.in_write_value = '0; bus1.in_reserve_number = '0;
      bus2.in_reg_number = '0; bus2.in_write_number = '0; bus2.in_write_value = '0; bus2.in_reserve_number = '0;
      idle_all();
      test_reset();
      test_forward();
      test_zero_reg();
      test_scoreboard();
      test_multiport();
      test_parity();
      test_reset_in_ready();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
